// File: rtl/spi_pkg.sv
// Shared constants for the SPI transfer engine: frame selects, the
// accelerometer command bytes, per-select frame lengths and engine states.
package spi_pkg;

  localparam logic [2:0] SEL_DUMMY = 3'b000;
  localparam logic [2:0] SEL_MEAS  = 3'b001;
  localparam logic [2:0] SEL_READ  = 3'b010;
  localparam logic [2:0] SEL_SRST  = 3'b011;

  // Command bytes: write/read opcodes followed by register address and data
  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;
  localparam logic [7:0] POWER_MEASURE  = 8'h02;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;

  // Frame lengths in bytes for transmit-only frames
  localparam logic [2:0] LEN_DUMMY = 3'd1;
  localparam logic [2:0] LEN_MEAS  = 3'd3;
  localparam logic [2:0] LEN_READ  = 3'd2;
  localparam logic [2:0] LEN_SRST  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } eng_state_t;

  // Byte idx of the transmit frame selected by sel; unused slots send 0x00
  function automatic logic [7:0] command_byte(input logic [2:0] sel, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      SEL_SRST: case (idx)
        3'd0:    b = CMD_WRITE;
        3'd1:    b = REG_SOFT_RESET;
        3'd2:    b = SOFT_RESET_KEY;
        default: b = 8'h00;
      endcase
      SEL_MEAS: case (idx)
        3'd0:    b = CMD_WRITE;
        3'd1:    b = REG_POWER_CTL;
        3'd2:    b = POWER_MEASURE;
        default: b = 8'h00;
      endcase
      SEL_READ: case (idx)
        3'd0:    b = CMD_READ;
        3'd1:    b = REG_XDATA_L;
        default: b = 8'h00;
      endcase
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Undefined selects behave like a single dummy byte
  function automatic logic [2:0] tx_frame_len(input logic [2:0] sel);
    logic [2:0] n;
    case (sel)
      SEL_SRST: n = LEN_SRST;
      SEL_MEAS: n = LEN_MEAS;
      SEL_READ: n = LEN_READ;
      default:  n = LEN_DUMMY;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One-byte SPI shift register. sr[7] is the bit on mosi; the incoming miso
// bit is parked in rx_bit at the rising sclk edge and enters sr at the
// falling edge, so the same register carries TX and RX data.
module spi_byte_shifter
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       sample,
  input  logic       shift,
  input  logic       miso,
  output logic       mosi_bit,
  output logic [7:0] rx_byte,
  output logic       byte_end
);

  logic [7:0] sr;
  logic       rx_bit;
  logic [2:0] bit_cnt;

  // Load wins over shift: at a byte boundary the next TX byte replaces the
  // finished one after its received value has been taken from rx_byte.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sr      <= 8'h00;
      rx_bit  <= 1'b0;
      bit_cnt <= 3'd0;
    end else begin
      if (sample) rx_bit <= miso;
      if (load) begin
        sr      <= load_byte;
        bit_cnt <= 3'd0;
      end else if (shift) begin
        sr      <= {sr[6:0], rx_bit};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign mosi_bit = sr[7];
  assign rx_byte  = {sr[6:0], rx_bit};
  assign byte_end = (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 bit/byte engine for one accelerometer. Sends the command frame
// chosen by data_select, or clocks in RX_BYTES burst bytes and publishes
// them as X/Y/Z samples. Every output comes straight from a flop.
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int RX_BYTES = 6,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        data_select,
  input  logic              transfer,
  input  logic              receive,
  input  logic              cs,
  input  logic              byte_reset,
  input  logic              miso,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              spi_cs_n,
  output logic [DATA_W-1:0] x_data,
  output logic [DATA_W-1:0] y_data,
  output logic [DATA_W-1:0] z_data,
  output logic              data_valid
);

  // Byte indices are 3 bits wide, so a frame holds at most 7 bytes
  localparam logic [2:0] RX_LEN = 3'(RX_BYTES);

  eng_state_t state, state_n;

  logic [2:0] frm_len;
  logic [2:0] byte_idx;
  logic [2:0] sel_q;
  logic       rx_frame;
  logic [RX_BYTES-1:0][7:0] shadow;
  logic [RX_BYTES-1:0][7:0] frame_bytes;

  logic       sh_clr, sh_load, sh_sample, sh_shift;
  logic [7:0] sh_load_byte;
  logic       start, byte_adv, byte_cap, last_bit, discard;

  logic       sh_mosi;
  logic [7:0] rx_byte;
  logic       byte_end;

  spi_byte_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clr       (sh_clr),
    .load      (sh_load),
    .load_byte (sh_load_byte),
    .sample    (sh_sample),
    .shift     (sh_shift),
    .miso      (miso),
    .mosi_bit  (sh_mosi),
    .rx_byte   (rx_byte),
    .byte_end  (byte_end)
  );

  // Engine state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next state and shifter controls; byte_reset overrides everything
  always_comb begin
    state_n      = state;
    sh_clr       = 1'b0;
    sh_load      = 1'b0;
    sh_load_byte = 8'h00;
    sh_sample    = 1'b0;
    sh_shift     = 1'b0;
    start        = 1'b0;
    byte_adv     = 1'b0;
    byte_cap     = 1'b0;
    last_bit     = 1'b0;
    discard      = 1'b0;
    if (byte_reset) begin
      state_n = ST_IDLE;
      sh_clr  = 1'b1;
      discard = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (transfer) begin
          state_n      = ST_LOW;
          start        = 1'b1;
          sh_load      = 1'b1;
          sh_load_byte = receive ? 8'h00 : command_byte(data_select, 3'd0);
        end
        ST_LOW: if (!transfer) begin
          state_n = ST_IDLE;
          sh_clr  = 1'b1;
          discard = 1'b1;
        end else begin
          state_n   = ST_HIGH;
          sh_sample = 1'b1;
        end
        ST_HIGH: if (!transfer) begin
          state_n = ST_IDLE;
          sh_clr  = 1'b1;
          discard = 1'b1;
        end else if (byte_end) begin
          byte_cap = 1'b1;
          if (byte_idx == frm_len - 3'd1) begin
            state_n  = ST_DONE;
            sh_clr   = 1'b1;
            last_bit = 1'b1;
          end else begin
            state_n      = ST_LOW;
            sh_shift     = 1'b1;
            sh_load      = 1'b1;
            sh_load_byte = rx_frame ? 8'h00 : command_byte(sel_q, byte_idx + 3'd1);
            byte_adv     = 1'b1;
          end
        end else begin
          state_n  = ST_LOW;
          sh_shift = 1'b1;
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Pin and strobe registers, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk       <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      spi_cs_n   <= 1'b1;
    end else begin
      sclk       <= (state_n == ST_HIGH);
      done       <= (state_n == ST_DONE);
      data_valid <= last_bit && rx_frame;
      spi_cs_n   <= cs;
    end
  end

  assign mosi = sh_mosi;

  // Frame descriptor latched at start; byte counter clears on leaving the frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      frm_len  <= 3'd0;
      byte_idx <= 3'd0;
      sel_q    <= SEL_DUMMY;
      rx_frame <= 1'b0;
    end else if (start) begin
      frm_len  <= receive ? RX_LEN : tx_frame_len(data_select);
      sel_q    <= data_select;
      rx_frame <= receive;
      byte_idx <= 3'd0;
    end else if (state_n == ST_IDLE || state_n == ST_DONE) begin
      byte_idx <= 3'd0;
    end else if (byte_adv) begin
      byte_idx <= byte_idx + 3'd1;
    end
  end

  // Received bytes collect in shadow; aborted frames throw them away
  always_ff @(posedge clk) begin
    if (!reset || discard) begin
      shadow <= '0;
    end else if (byte_cap && rx_frame) begin
      shadow[byte_idx] <= rx_byte;
    end
  end

  // The last byte is still in the shifter when the frame completes
  always_comb begin
    for (int i = 0; i < RX_BYTES; i++)
      frame_bytes[i] = (byte_idx == 3'(i)) ? rx_byte : shadow[i];
  end

  // Publish all three axes together on the completing edge of a receive frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_data <= '0;
      y_data <= '0;
      z_data <= '0;
    end else if (last_bit && rx_frame) begin
      x_data <= DATA_W'({frame_bytes[1], frame_bytes[0]});
      y_data <= DATA_W'({frame_bytes[3], frame_bytes[2]});
      z_data <= DATA_W'({frame_bytes[5], frame_bytes[4]});
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Bench for spi_xfer_engine: a table of known frames, random frames checked
// against a transaction-level sensor model, and hand-written corner cases.
module tb_spi_xfer_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  data_select = 3'b000;
  logic        transfer = 1'b0, receive = 1'b0, cs = 1'b1, byte_reset = 1'b0, miso = 1'b0;
  logic        done, sclk, mosi, spi_cs_n, data_valid;
  logic [15:0] x_data, y_data, z_data;

  spi_xfer_engine #(.RX_BYTES(6), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .data_select(data_select), .transfer(transfer),
    .receive(receive), .cs(cs), .byte_reset(byte_reset), .miso(miso),
    .done(done), .sclk(sclk), .mosi(mosi), .spi_cs_n(spi_cs_n),
    .x_data(x_data), .y_data(y_data), .z_data(z_data), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      sel;
    bit              rx;
    logic [5:0][7:0] miso_b;
    int              exp_done;
    logic [5:0][7:0] exp_mosi;
    bit              exp_dv;
    logic [15:0]     ex, ey, ez;
  } vec_t;

  int   n_tests = 0, n_fail = 0;
  bit   in_done = 1'b0;
  logic [15:0] mx = '0, my = '0, mz = '0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sensor-side view of the protocol: bytes per frame and what goes on mosi
  function automatic int exp_len(input logic [2:0] sel, input bit rx);
    if (rx) return 6;
    case (sel)
      3'b011:  return 3;
      3'b001:  return 3;
      3'b010:  return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] exp_cmd(input logic [2:0] sel, input bit rx, input int i);
    logic [7:0] srst[3] = '{8'h0A, 8'h1F, 8'h52};
    logic [7:0] meas[3] = '{8'h0A, 8'h2D, 8'h02};
    logic [7:0] rd[2]   = '{8'h0B, 8'h0E};
    if (rx) return 8'h00;
    case (sel)
      3'b011:  return srst[i];
      3'b001:  return meas[i];
      3'b010:  return rd[i];
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle(input int n);
    transfer = 1'b0;
    cs = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    in_done = 1'b0;
  endtask

  // Run one frame from the current cycle (or right after a previous done,
  // leaving transfer high through that done cycle) and check everything.
  task automatic do_frame(input string tag, input vec_t v);
    int n, k, b, done_cyc, err;
    logic [5:0][7:0] got;
    logic dv;
    logic [15:0] ox, oy, oz;
    n = (v.exp_done - 1) / 16;
    data_select = v.sel; receive = v.rx; transfer = 1'b1; cs = 1'b0;
    err = 0;
    if (in_done) begin
      @(posedge clk); #1;
      if (sclk !== 1'b0 || done !== 1'b0) err++;
    end
    in_done = 1'b0;
    done_cyc = -1; got = '0; dv = 1'b0; ox = '0; oy = '0; oz = '0;
    for (k = 1; k <= 16 * n + 4; k++) begin
      @(posedge clk); #1;
      if (sclk !== ((k % 2 == 0) && (k <= 16 * n))) err++;
      if (data_valid === 1'b1 && done !== 1'b1) err++;
      if (k % 2 == 0 && k <= 16 * n) begin
        b = (k / 2 - 1) / 8;
        got[b] = {got[b][6:0], mosi};
      end
      if (k % 2 == 1 && k < 16 * n) begin
        b = (k - 1) / 2;
        miso = v.miso_b[b / 8][7 - b % 8];
      end
      if (done === 1'b1) begin
        done_cyc = k; dv = data_valid; ox = x_data; oy = y_data; oz = z_data;
        break;
      end
    end
    chk({tag, " done_cycle"}, done_cyc, v.exp_done);
    chk({tag, " sclk_pattern_errs"}, err, 0);
    for (int i = 0; i < n; i++) chk({tag, $sformatf(" mosi_byte%0d", i)}, got[i], v.exp_mosi[i]);
    chk({tag, " data_valid"}, dv, v.exp_dv);
    chk({tag, " xyz"}, {ox, oy}, {v.ex, v.ey});
    chk({tag, " z"}, oz, v.ez);
    in_done = (done_cyc >= 0);
  endtask

  // Build expectations for a frame from the model and advance the model
  task automatic mk(input logic [2:0] sel, input bit rx, input logic [5:0][7:0] mb, output vec_t v);
    int n;
    n = exp_len(sel, rx);
    v.sel = sel; v.rx = rx; v.miso_b = mb; v.exp_done = 16 * n + 1;
    v.exp_mosi = '0;
    for (int i = 0; i < n; i++) v.exp_mosi[i] = exp_cmd(sel, rx, i);
    v.exp_dv = rx;
    if (rx) begin
      mx = {mb[1], mb[0]}; my = {mb[3], mb[2]}; mz = {mb[5], mb[4]};
    end
    v.ex = mx; v.ey = my; v.ez = mz;
  endtask

  initial begin
    vec_t v;
    logic [5:0][7:0] mb;
    logic prev_cs, nv;
    int hits;

    tbl[0] = '{3'b011, 1'b0, 48'h0, 49, 48'h0000_0052_1F0A, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{3'b010, 1'b0, 48'h0, 33, 48'h0000_0000_0E0B, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{3'b010, 1'b1, 48'h8001_ABCD_1234, 97, 48'h0, 1'b1, 16'h1234, 16'hABCD, 16'h8001};
    tbl[3] = '{3'b001, 1'b0, 48'hFFFF_FFFF_FFFF, 49, 48'h0000_0002_2D0A, 1'b0, 16'h1234, 16'hABCD, 16'h8001};
    tbl[4] = '{3'b000, 1'b0, 48'h0, 17, 48'h0, 1'b0, 16'h1234, 16'hABCD, 16'h8001};
    tbl[5] = '{3'b011, 1'b1, 48'h00FF_F00F_AA55, 97, 48'h0, 1'b1, 16'hAA55, 16'hF00F, 16'h00FF};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset sclk", sclk, 1'b0);
    chk("reset mosi", mosi, 1'b0);
    chk("reset spi_cs_n", spi_cs_n, 1'b1);
    chk("reset done_dv", {done, data_valid}, 2'b00);
    chk("reset xyz", {x_data, y_data, z_data}, 48'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Known frames, run back to back
    for (int i = 0; i < 6; i++) do_frame($sformatf("tbl%0d", i), tbl[i]);
    mx = tbl[5].ex; my = tbl[5].ey; mz = tbl[5].ez;
    idle(2);

    // Abort after 5 sclk highs of a measurement frame
    data_select = 3'b001; receive = 1'b0; transfer = 1'b1; cs = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort sclk_before", sclk, 1'b1);
    transfer = 1'b0;
    @(posedge clk); #1;
    chk("abort sclk_after", sclk, 1'b0);
    hits = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || data_valid === 1'b1 || sclk === 1'b1) hits++; end
    chk("abort no_done", hits, 0);
    mk(3'b001, 1'b0, 48'h0, v);
    do_frame("after_abort", v);
    idle(2);

    // byte_reset coincident with transfer delays the start by one cycle
    data_select = 3'b000; receive = 1'b0; transfer = 1'b1; byte_reset = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    byte_reset = 1'b0;
    mk(3'b000, 1'b0, 48'h0, v);
    do_frame("byte_reset", v);
    idle(2);

    // Reset in the middle of the fourth received byte
    data_select = 3'b010; receive = 1'b1; transfer = 1'b1; cs = 1'b0;
    for (int k = 1; k <= 16 * 3 + 5; k++) begin
      @(posedge clk); #1;
      miso = 1'($urandom);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset sclk", sclk, 1'b0);
    chk("midreset spi_cs_n", spi_cs_n, 1'b1);
    chk("midreset xyz", {x_data, y_data, z_data}, 48'h0);
    chk("midreset done_dv_mosi", {done, data_valid, mosi}, 3'b000);
    reset = 1'b1; transfer = 1'b0; mx = '0; my = '0; mz = '0; in_done = 1'b0;
    @(posedge clk); #1;
    mb = {16'h8001, 16'hABCD, 16'h1234};
    mk(3'b010, 1'b1, mb, v);
    do_frame("post_reset_rx", v);
    idle(2);

    // cs shows up on spi_cs_n exactly one cycle later
    prev_cs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nv = (i % 3 == 2) ? prev_cs : ~prev_cs;
      cs = nv;
      chk($sformatf("cs_hold%0d", i), spi_cs_n, prev_cs);
      @(posedge clk); #1;
      chk($sformatf("cs_delay%0d", i), spi_cs_n, nv);
      prev_cs = nv;
    end
    idle(1);

    // Random frames against the model, sometimes back to back
    for (int i = 0; i < 20; i++) begin
      mb = {$urandom, $urandom[15:0]};
      mk(3'($urandom % 4), ($urandom % 3 == 0), mb, v);
      do_frame($sformatf("rnd%0d", i), v);
      if ($urandom % 2 == 1) idle(1 + $urandom % 3);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_engine.md
Name: spi_xfer_engine

Overview:
- SPI bit/byte datapath directly downstream of the accelerometer sequencing FSM; one instance per sensor.
- Consumes the FSM's data_select/transfer/receive/cs/byte_reset and returns a one-cycle done per phase.
- Drives the mode-0 SPI pins (sclk, mosi, spi_cs_n) and samples miso.
- Assembles the six burst-read bytes into X/Y/Z samples for the downstream consumer.

Parameters:
- RX_BYTES, 6, bytes clocked in during a receive phase (XL, XH, YL, YH, ZL, ZH)
- DATA_W, 16, width of each axis output

Ports:
- clk  in  1  5 MHz system/SPI clock
- reset  in  1  synchronous active-low reset (reset==0 resets on next clk rising edge)
- data_select  in  3  frame select: 000 dummy, 001 measurement-mode, 010 read command, 011 soft reset
- transfer  in  1  frame enable; held high by FSM until done
- receive  in  1  receive phase; when high, bytes received on miso are captured
- cs  in  1  chip select from FSM, active low
- byte_reset  in  1  clears byte/bit counters and shadow registers
- miso  in  1  serial data from sensor
- done  out  1  one-cycle pulse: current frame complete
- sclk  out  1  SPI clock, idle low (CPOL=0, CPHA=0)
- mosi  out  1  serial data to sensor, MSB first
- spi_cs_n  out  1  registered copy of cs
- x_data, y_data, z_data  out  DATA_W each  {H,L} assembled axis samples
- data_valid  out  1  one-cycle pulse when x/y/z update

Behaviour:
- Reset: sclk=0, mosi=0, spi_cs_n=1, done=0, data_valid=0, x/y/z=0, counters=0, engine IDLE.
- Engine states: IDLE, LOW (sclk=0, mosi holds current bit), HIGH (sclk=1), DONE.
- IDLE->LOW on first cycle with transfer=1. At that edge, latch frame length: receive ? RX_BYTES : (010 -> 2, 001 -> 3, 011 -> 3, 000 -> 1). Load tx byte from the command table.
- Command table:
  - 011: 0x0A, 0x1F, 0x52
  - 001: 0x0A, 0x2D, 0x02
  - 010: 0x0B, 0x0E
  - 000 or receive=1: 0x00 for every byte
- Each bit takes 2 clk cycles (LOW then HIGH).
  - miso is sampled on the edge LOW->HIGH.
  - mosi advances on the edge HIGH->LOW.
  - A frame of N bytes is 16N cycles of LOW/HIGH.
- After the final HIGH, the engine enters DONE for one cycle with done=1, then returns to IDLE.
  - Byte and bit counters self-clear at DONE, so a SEND->RECEIVE back-to-back with no byte_reset is legal.
- Latency: transfer first high in cycle 0 -> sclk first high in cycle 2 -> done high in cycle 16N+1.
- A new frame starts only from IDLE. transfer still high in the DONE cycle is ignored.
- Receive:
  - Byte k (0..5) shifts into shadow register k.
  - On DONE of a receive frame, x={b1,b0}, y={b3,b2}, z={b5,b4} update simultaneously and data_valid pulses in the same cycle as done.
  - Outputs hold between updates.
- Non-receive frames never alter x/y/z or assert data_valid.
- Abort: transfer=0 in LOW or HIGH -> next cycle IDLE, sclk=0, counters cleared, no done, shadow bytes discarded.
- byte_reset=1: clears counters/shadow and forces IDLE; it has priority over transfer in the same cycle. x/y/z keep their values.
- spi_cs_n = cs delayed 1 cycle, aligned with sclk/mosi registers.
- reset low mid-frame: all outputs return to reset values at the next edge; a partial sample is never published.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Package spi_pkg holds:
  - data_select localparams (SEL_DUMMY, SEL_MEAS, SEL_READ, SEL_SRST)
  - command byte constants and per-select frame lengths
  - a command_byte(sel, idx) function
- Sub-module spi_byte_shifter: 8-bit parallel-load TX/RX shift register with 3-bit bit counter and byte_end flag. Instantiated once.

Test Plan:
- Soft reset: sel=011, transfer=1, miso=0 -> mosi bytes 0x0A,0x1F,0x52 on 24 sclk rising edges; done at cycle 49; data_valid=0.
- Read sequence: sel=010 frame, then receive=1 immediately after done. Sensor model returns 0x34,0x12,0xCD,0xAB,0x01,0x80 -> x=0x1234, y=0xABCD, z=0x8001; data_valid coincident with second done; mosi=0 throughout the receive frame.
- Abort: drop transfer after 5 sclk highs of measurement frame -> sclk=0 next cycle, no done. A later sel=001 frame sends the full 0x0A,0x2D,0x02.
- Reset mid-receive: reset=0 at byte 3 -> x/y/z stay 0, spi_cs_n=1, sclk=0. The next full receive publishes the correct values.
- byte_reset coincident with transfer=1 -> engine stays IDLE that cycle and the frame starts one cycle later; cs toggling reflected on spi_cs_n exactly 1 cycle later.
